// File: rtl/unsigned_multiply_add.sv
// unsigned_multiply_add
//   Iterative shift-and-add multiply-accumulate:
//   o_product = i_multiplicand * i_multiplier + i_addend (all unsigned).
//   One multiplier bit is consumed per clock, so the latency is a fixed
//   WIDTH cycles from start to result. It is the inverse of the unsigned
//   divider: quotient * divisor + remainder rebuilds the dividend.
//
// Ports
//   i_clk           clock, rising edge
//   i_reset_n       asynchronous active-low reset
//   i_start         start pulse, honoured only while o_ready is high
//   i_multiplicand  WIDTH-bit operand, sampled with i_start
//   i_multiplier    WIDTH-bit operand, sampled with i_start
//   i_addend        WIDTH-bit operand, sampled with i_start
//   o_ready         idle, a new operation may start
//   o_valid         one-cycle result strobe
//   o_product       2*WIDTH-bit result, zero while o_valid is low
//   o_overflow      upper half of the result is non-zero, zero while o_valid is low
module unsigned_multiply_add #(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
  input  logic [WIDTH-1:0]   i_addend,
  output logic               o_ready,
  output logic               o_valid,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_overflow
);

  // One extra bit so the counter can represent WIDTH itself without wrapping.
  localparam int SW = $clog2(WIDTH) + 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [2*WIDTH-1:0] acc;     // running sum, seeded with the addend
  logic [2*WIDTH-1:0] mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]   mplier;  // multiplier, shifted right each step
  logic [SW-1:0]      step;

  logic               load;
  logic               last_step;

  assign load      = (state == IDLE) && i_start;
  assign last_step = (step == LAST_STEP);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // ---------------------------------------------------------------------
  // Next-state logic. BUSY always runs the full WIDTH steps; there is no
  // early exit on a zero multiplier so the latency never depends on data.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start)   state_nxt = BUSY;
      BUSY:    if (last_step) state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs, decoded from registered state only. The product bus is
  // forced to zero outside DONE so downstream never sees partial sums.
  // ---------------------------------------------------------------------
  always_comb begin
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    o_product  = '0;
    o_overflow = 1'b0;
    case (state)
      IDLE: o_ready = 1'b1;
      DONE: begin
        o_valid    = 1'b1;
        o_product  = acc;
        o_overflow = |acc[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath. Max result is (2^W-1)^2 + (2^W-1) = 2^2W - 2^W, so the
  // 2W-bit accumulator cannot wrap and no carry-out is kept.
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      step   <= '0;
    end else if (load) begin
      acc    <= {{WIDTH{1'b0}}, i_addend};
      mcand  <= {{WIDTH{1'b0}}, i_multiplicand};
      mplier <= i_multiplier;
      step   <= '0;
    end else if (state == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + SW'(1);
    end
  end

endmodule

// File: tb/tb_unsigned_multiply_add.sv
// Scoreboard bench for unsigned_multiply_add (WIDTH=16). The driver pushes
// a*b+c (plain 64-bit arithmetic) with the expected result cycle; the
// monitor pops on every o_valid and also checks idle/reset output values,
// ready-low run length and back-to-back spacing.
module tb_unsigned_multiply_add;
  localparam int W = 16;

  typedef struct {
    logic [2*W-1:0] prod;
    logic           ovf;
    int             cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a = '0, b = '0, c = '0;
  logic           ready, valid, ovf;
  logic [2*W-1:0] prod;

  exp_t q[$];
  int   cyc = 0;
  int   vec = 0, err = 0;          // monitor counters
  int   drv_vec = 0, drv_err = 0;  // driver counters
  int   valid_cnt = 0;
  int   run = 0;
  int   prev_valid = -1;
  bit   b2b = 1'b0;

  unsigned_multiply_add #(.WIDTH(W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .i_multiplicand(a), .i_multiplier(b), .i_addend(c),
    .o_ready(ready), .o_valid(valid), .o_product(prod), .o_overflow(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      run = 0;
      vec++;
      if (ready !== 1'b1 || valid !== 1'b0 || prod !== '0 || ovf !== 1'b0) begin
        err++;
        $display("FAIL reset_vals ready=%b valid=%b prod=%h ovf=%b required 1 0 0 0",
                 ready, valid, prod, ovf);
      end
    end else begin
      if (ready && valid) begin
        vec++; err++;
        $display("FAIL ready_and_valid both high at cyc %0d", cyc);
      end
      if (valid) begin
        valid_cnt++;
        vec++;
        if (q.size() == 0) begin
          err++;
          $display("FAIL unexpected_valid prod=%h with empty scoreboard", prod);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (prod !== e.prod || ovf !== e.ovf || cyc != e.cyc) begin
            err++;
            $display("FAIL result prod=%h ovf=%b cyc=%0d required prod=%h ovf=%b cyc=%0d",
                     prod, ovf, cyc, e.prod, e.ovf, e.cyc);
          end
        end
        if (b2b && prev_valid >= 0) begin
          vec++;
          if (cyc - prev_valid != W + 2) begin
            err++;
            $display("FAIL spacing got %0d required %0d", cyc - prev_valid, W + 2);
          end
        end
        prev_valid = b2b ? cyc : -1;
      end else begin
        vec++;
        if (prod !== '0 || ovf !== 1'b0) begin
          err++;
          $display("FAIL idle_outputs prod=%h ovf=%b required 0 0", prod, ovf);
        end
        if (!b2b) prev_valid = -1;
      end
      if (!ready) run++;
      else if (run > 0) begin
        vec++;
        if (run != W + 1) begin
          err++;
          $display("FAIL ready_low_run got %0d required %0d", run, W + 1);
        end
        run = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called on a negedge; waits (bounded) for ready, presents one start pulse.
  task automatic issue(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic [W-1:0] mc);
    int   n = 0;
    exp_t e;
    longint unsigned p;
    while (!ready && n < 100) begin @(negedge clk); n++; end
    if (!ready) begin
      drv_vec++; drv_err++;
      $display("FAIL ready_timeout ready=%b required 1", ready);
    end else begin
      a = ma; b = mb; c = mc; start = 1'b1;
      p = longint'(ma) * longint'(mb) + longint'(mc);
      e.prod = p[2*W-1:0];
      e.ovf  = (p >> W) != 0;
      e.cyc  = cyc + 1 + W;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    @(negedge clk);
    drv_vec++;
    if (q.size() != 0) begin
      drv_err++;
      $display("FAIL drain_timeout pending=%0d required 0", q.size());
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int base;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // directed values
    issue(16'd142, 16'd7, 16'd6);          // 1000
    drain();
    issue(16'h1234, 16'h0100, 16'h0000);   // 0x00123400, overflow
    drain();
    issue(16'hFFFF, 16'hFFFF, 16'hFFFF);   // 0xFFFF0000
    drain();
    issue(16'h0000, 16'hFFFF, 16'h0007);   // 7
    drain();
    issue(16'hFFFF, 16'h0000, 16'h0000);   // 0
    drain();

    // abort: reset 5 cycles into an operation, no valid must appear
    base = valid_cnt;
    issue(16'hABCD, 16'h1357, 16'h2468);
    repeat (4) @(negedge clk);
    do_reset();
    repeat (W + 4) @(negedge clk);
    drv_vec++;
    if (valid_cnt != base) begin
      drv_err++;
      $display("FAIL abort_valid got %0d pulses required 0", valid_cnt - base);
    end
    issue(16'd3, 16'd5, 16'd2);            // 17, no stale accumulator
    drain();

    // handshake: starts while busy are ignored
    base = valid_cnt;
    issue(16'd9, 16'd9, 16'd0);
    for (int i = 0; i < W + 2; i++) begin
      if (!ready) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
    end
    drain();
    drv_vec++;
    if (valid_cnt - base != 1) begin
      drv_err++;
      $display("FAIL busy_start_pulses got %0d required 1", valid_cnt - base);
    end

    // back-to-back random
    b2b = 1'b1;
    for (int i = 0; i < 1000; i++)
      issue(W'($urandom), W'($urandom), W'($urandom));
    drain();
    b2b = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec + drv_vec, err + drv_err);
    $finish;
  end

endmodule

// File: doc/unsigned_multiply_add.md
# unsigned_multiply_add

Iterative shift-and-add unit computing `o_product = i_multiplicand * i_multiplier + i_addend` on unsigned operands. It uses the same start/ready/valid handshake as the GPU's unsigned divider and is its inverse: `quotient * divisor + remainder` reconstructs the dividend. It sits beside the divider in the GPU arithmetic path for address and scale computation and for divide checking. It trades latency (one multiplier bit per clock) for area.

## Interface
- `WIDTH`, default 16: operand width in bits. Must be ≥ 2.
- `i_clk` — in, 1: clock, rising edge.
- `i_reset_n` — in, 1: reset, asynchronous, active-low.
- `i_start` — in, 1: high for one tick to start an operation. Honoured only while `o_ready` is high.
- `i_multiplicand` — in, WIDTH: must be valid on the tick `i_start` is high.
- `i_multiplier` — in, WIDTH: must be valid on the tick `i_start` is high.
- `i_addend` — in, WIDTH: must be valid on the tick `i_start` is high.
- `o_ready` — out, 1: high when a new operation can start.
- `o_valid` — out, 1: high for exactly one tick when the result is complete.
- `o_product` — out, 2*WIDTH: the result. Valid while `o_valid` is high; 0 otherwise.
- `o_overflow` — out, 1: high when `o_product[2*WIDTH-1:WIDTH]` is non-zero. Valid while `o_valid` is high; 0 otherwise.

## Operation
- States are IDLE, BUSY and DONE.
  - `o_ready` = (state == IDLE).
  - `o_valid` = (state == DONE).
- IDLE → BUSY when `i_start` is high at a clock edge. On that edge, load:
  - accumulator (2*WIDTH bits) = zero-extended `i_addend`;
  - shifted multiplicand (2*WIDTH bits) = zero-extended `i_multiplicand`;
  - multiplier shift register = `i_multiplier`;
  - step counter = 0.
- BUSY: on each edge,
  - if the multiplier LSB is 1, accumulator += shifted multiplicand;
  - shifted multiplicand <<= 1; multiplier >>= 1; step += 1.
  - After WIDTH such edges the state goes to DONE.
  - Latency is fixed: there is no early exit on a zero multiplier.
- DONE: `o_product` = accumulator and `o_overflow` = |accumulator[2W-1:W]. Next edge goes to IDLE unconditionally.
- `i_start` while in BUSY or DONE is ignored. The operand inputs are don't-care outside the start tick.
- Width rule: the maximum result is (2^W−1)^2 + (2^W−1) = 2^2W − 2^W, so the 2W-bit accumulator never wraps. No carry-out is needed.
- The step counter is $clog2(WIDTH)+1 bits and must not wrap before reaching WIDTH.

## Timing
- Reset values (asynchronous, while `i_reset_n` is low):
  - state IDLE, so `o_ready` = 1;
  - `o_valid` = 0, `o_product` = 0, `o_overflow` = 0;
  - internal registers = 0.
- Reset mid-operation aborts immediately: no `o_valid` pulse, and the block is in IDLE on release.
- Let E0 be the edge that samples `i_start`:
  - `o_ready` falls after E0.
  - BUSY covers E1..E_WIDTH.
  - `o_valid` is high between E_WIDTH and E_WIDTH+1.
  - `o_ready` rises after E_WIDTH+1.
- Cycle counts:
  - Start-to-valid: WIDTH cycles.
  - Earliest next start: sampled at E_WIDTH+2.
  - Throughput: one operation per WIDTH+2 cycles.
- `o_ready` and `o_valid` are never high in the same cycle.
- All outputs are decoded from registered state only, so they are glitch-free relative to the inputs.

## Test plan
- Reset: assert `i_reset_n` low mid-stream → `o_ready`=1, `o_valid`=0, `o_product`=0, `o_overflow`=0. After release, a new start with 3, 5, 2 (WIDTH=16) → `o_product`=17 exactly 16 cycles later.
- Basic and round-trip (WIDTH=16):
  - 142*7+6 → `o_product`=1000 (divider inverse of 1000/7), `o_overflow`=0.
  - 0x1234*0x0100+0 → 0x00123400, `o_overflow`=1.
- Extremes (WIDTH=16):
  - 0xFFFF*0xFFFF+0xFFFF → 0xFFFF0000, `o_overflow`=1.
  - 0*0xFFFF+7 → 7.
  - 0xFFFF*0+0 → 0.
  - Each takes 16 cycles regardless of operands.
- Handshake:
  - Pulse `i_start` with 9*9+0, then pulse `i_start` with different operands every cycle while busy → only 81 produced, exactly one `o_valid` pulse.
  - `o_ready` low for exactly WIDTH+1 cycles.
- Back-to-back: issue a start on the first cycle `o_ready` is high, for 1000 random operand sets → each `o_product` matches the reference model `a*b+c`, spacing is WIDTH+2 cycles, and `o_product`=0 whenever `o_valid` is low.
- Abort: reset asserted 5 cycles into an operation → no `o_valid`. After release, the next operation completes correctly with no stale accumulator contribution.
